// File: rtl/motor_step_pkg.sv
// Shared types and default parameter values for the step/dir channel array.
package motor_step_pkg;

  // Per-channel sequencer phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PULSE = 2'd2,
    POST  = 2'd3
  } motor_state_e;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_TW     = 32;
  localparam int DEF_PEND_W = 4;
  localparam int DEF_POS_W  = 32;

endpackage

// File: rtl/motor_step_chan.sv
// One step/dir channel: IDLE -> PRE -> PULSE -> POST sequencer with a
// same-direction pending-step queue, sticky overrun flag and an optional
// position counter (built only when MOTOR_STEP_POSITION_EN is defined).
module motor_step_chan
  import motor_step_pkg::*;
#(
  parameter int TW     = DEF_TW,
  parameter int PEND_W = DEF_PEND_W,
  parameter int POS_W  = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_stb,
  input  logic             step_dir,
  input  logic             enable,
  input  logic             invert,
  input  logic [TW-1:0]    pre_n,
  input  logic [TW-1:0]    pulse_n,
  input  logic [TW-1:0]    post_n,
  input  logic             clear_pos,
  input  logic             clear_ovr,
  output logic             step,
  output logic             dir,
  output logic             pend_nz,
  output logic             overrun,
  output motor_state_e     state_o,
  output logic [POS_W-1:0] position
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  motor_state_e      state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     pre_q, pre_d;
  logic [TW-1:0]     pulse_q, pulse_d;
  logic [TW-1:0]     post_q, post_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              dir_q, dir_d;
  logic              raw_q, raw_d;
  logic              ovr_q, ovr_d;

  logic req;
  logic expire;
  logic q_ok;
  logic q_drop;

  // A zero-length phase still lasts one cycle; the counter holds cycles left minus one.
  function automatic logic [TW-1:0] ph_len(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  // Next-state, queue and overrun decisions for this channel.
  always_comb begin
    req    = step_stb & enable;
    expire = (cnt_q == '0);
    q_ok   = (state_q != IDLE) && req && (step_dir == dir_q) && (pend_q != PEND_MAX);
    q_drop = (state_q != IDLE) && req && !q_ok;

    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    pulse_d = pulse_q;
    post_d  = post_q;
    dir_d   = dir_q;
    raw_d   = 1'b0;
    pend_d  = q_ok ? pend_q + PEND_W'(1) : pend_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = PRE;
          cnt_d   = ph_len(pre_n);
          pre_d   = pre_n;
          pulse_d = pulse_n;
          post_d  = post_n;
          dir_d   = step_dir;
        end
      end
      PRE: begin
        if (expire) begin
          state_d = PULSE;
          cnt_d   = ph_len(pulse_q);
          raw_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      PULSE: begin
        if (expire) begin
          state_d = POST;
          cnt_d   = ph_len(post_q);
        end else begin
          cnt_d = cnt_q - TW'(1);
          raw_d = 1'b1;
        end
      end
      POST: begin
        if (expire) begin
          // A request arriving in the last POST cycle chains straight on, no gap.
          if (enable && ((pend_q != '0) || q_ok)) begin
            state_d = PRE;
            cnt_d   = ph_len(pre_q);
            pend_d  = pend_d - PEND_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
    endcase

    if (!enable) begin
      pend_d = '0;
    end

    // Set wins over clear.
    ovr_d = (ovr_q & ~clear_ovr) | q_drop;
  end

  // Sequencer registers; reset drops the raw step level without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      pulse_q <= '0;
      post_q  <= '0;
      pend_q  <= '0;
      dir_q   <= 1'b0;
      raw_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
      post_q  <= post_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      raw_q   <= raw_d;
      ovr_q   <= ovr_d;
    end
  end

  assign step    = raw_q ^ invert;
  assign dir     = dir_q;
  assign pend_nz = (pend_q != '0);
  assign overrun = ovr_q;
  assign state_o = state_q;

`ifdef MOTOR_STEP_POSITION_EN
  logic [POS_W-1:0] pos_q, pos_d;

  // Position moves on the PRE-to-PULSE edge; clear_pos wins over a coincident move.
  always_comb begin
    pos_d = pos_q;
    if ((state_q == PRE) && expire) begin
      pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
    if (clear_pos) begin
      pos_d = '0;
    end
  end

  // Position register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;
`else
  logic unused_clear_pos;
  assign unused_clear_pos = clear_pos;
  assign position         = '0;
`endif

endmodule

// File: rtl/motor_step_array.sv
// Array of N_CH independent step/dir pulse generators sharing timing inputs
// and clear strobes. Position counters are built only with
// MOTOR_STEP_POSITION_EN defined; otherwise position reads as zero.
//
// Request protocol: step_stb is a one-cycle request with no ready. An idle,
// enabled channel always takes it; a busy channel queues it (same direction,
// queue not full) or drops it and raises the sticky overrun flag.
module motor_step_array
  import motor_step_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int TW     = DEF_TW,
  parameter int PEND_W = DEF_PEND_W,
  parameter int POS_W  = DEF_POS_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       step_stb,
  input  logic [N_CH-1:0]       step_dir,
  input  logic [N_CH-1:0]       enable,
  input  logic [TW-1:0]         pre_n,
  input  logic [TW-1:0]         pulse_n,
  input  logic [TW-1:0]         post_n,
  input  logic [N_CH-1:0]       invert,
  input  logic                  clear_pos,
  input  logic                  clear_ovr,
  output logic [N_CH-1:0]       step,
  output logic [N_CH-1:0]       dir,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       overrun,
  output logic [N_CH*POS_W-1:0] position
);

  motor_state_e    chan_state [N_CH];
  logic [N_CH-1:0] pend_nz;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    motor_step_chan #(
      .TW     (TW),
      .PEND_W (PEND_W),
      .POS_W  (POS_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .step_stb  (step_stb[g]),
      .step_dir  (step_dir[g]),
      .enable    (enable[g]),
      .invert    (invert[g]),
      .pre_n     (pre_n),
      .pulse_n   (pulse_n),
      .post_n    (post_n),
      .clear_pos (clear_pos),
      .clear_ovr (clear_ovr),
      .step      (step[g]),
      .dir       (dir[g]),
      .pend_nz   (pend_nz[g]),
      .overrun   (overrun[g]),
      .state_o   (chan_state[g]),
      .position  (position[g*POS_W +: POS_W])
    );

    // A channel is busy while sequencing or while steps are still queued.
    assign busy[g] = (chan_state[g] != IDLE) || pend_nz[g];
  end

endmodule

// File: tb/tb_motor_step_array.sv
// Bench for motor_step_array: directed scenarios with literal expectations
// plus a randomized phase, all continuously compared against a time-based
// behavioural model of each channel.
`timescale 1ns/1ps
module tb_motor_step_array;

  localparam int N_CH     = 4;
  localparam int TW       = 8;
  localparam int PEND_W   = 4;
  localparam int POS_W    = 8;   // narrow so the signed-max wrap is reachable
  localparam int PEND_MAX = (1 << PEND_W) - 1;
`ifdef MOTOR_STEP_POSITION_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       step_stb = '0;
  logic [N_CH-1:0]       step_dir = '0;
  logic [N_CH-1:0]       enable = '1;
  logic [TW-1:0]         pre_n = '0;
  logic [TW-1:0]         pulse_n = '0;
  logic [TW-1:0]         post_n = '0;
  logic [N_CH-1:0]       invert = '0;
  logic                  clear_pos = 1'b0;
  logic                  clear_ovr = 1'b0;
  logic [N_CH-1:0]       step;
  logic [N_CH-1:0]       dir;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       overrun;
  logic [N_CH*POS_W-1:0] position;

  always #5 clk = ~clk;

  motor_step_array #(
    .N_CH   (N_CH),
    .TW     (TW),
    .PEND_W (PEND_W),
    .POS_W  (POS_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step_stb  (step_stb),
    .step_dir  (step_dir),
    .enable    (enable),
    .pre_n     (pre_n),
    .pulse_n   (pulse_n),
    .post_n    (post_n),
    .invert    (invert),
    .clear_pos (clear_pos),
    .clear_ovr (clear_ovr),
    .step      (step),
    .dir       (dir),
    .busy      (busy),
    .overrun   (overrun),
    .position  (position)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by the elapsed cycle count inside the current
  // step and its three latched phase lengths; outputs follow from where the
  // elapsed count falls within pre | pulse | post.
  bit               m_act  [N_CH];
  int               m_el   [N_CH];
  int               m_p    [N_CH];
  int               m_u    [N_CH];
  int               m_s    [N_CH];
  int               m_pend [N_CH];
  bit               m_dir  [N_CH];
  bit               m_ovr  [N_CH];
  logic [POS_W-1:0] m_pos  [N_CH];

  function automatic int len1(input logic [TW-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        m_act[k] = 0; m_el[k] = 0; m_p[k] = 1; m_u[k] = 1; m_s[k] = 1;
        m_pend[k] = 0; m_dir[k] = 0; m_ovr[k] = 0; m_pos[k] = '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        bit req, inc, set_o;
        int tot;
        req   = step_stb[k] && enable[k];
        inc   = 0;
        set_o = 0;
        tot   = m_p[k] + m_u[k] + m_s[k];
        if (!m_act[k]) begin
          if (req) begin
            m_act[k] = 1; m_el[k] = 0;
            m_p[k] = len1(pre_n); m_u[k] = len1(pulse_n); m_s[k] = len1(post_n);
            m_dir[k] = step_dir[k];
          end
        end else begin
          if (req) begin
            if (step_dir[k] == m_dir[k] && m_pend[k] < PEND_MAX) inc = 1;
            else set_o = 1;
          end
          if (m_el[k] == m_p[k] - 1)
            m_pos[k] = m_dir[k] ? m_pos[k] + 1'b1 : m_pos[k] - 1'b1;
          if (m_el[k] == tot - 1) begin
            if (enable[k] && (m_pend[k] > 0 || inc)) begin
              m_el[k] = 0;
              m_pend[k] = m_pend[k] + int'(inc) - 1;
            end else begin
              m_act[k] = 0;
            end
          end else begin
            m_el[k]++;
            m_pend[k] += int'(inc);
          end
        end
        if (!enable[k]) m_pend[k] = 0;
        m_ovr[k] = (m_ovr[k] && !clear_ovr) || set_o;
        if (clear_pos) m_pos[k] = '0;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle out of reset ----------------
  always @(negedge clk) begin
    if (!reset) begin
      logic [N_CH-1:0]       e_step, e_dir, e_busy, e_ovr;
      logic [N_CH*POS_W-1:0] e_pos;
      for (int k = 0; k < N_CH; k++) begin
        e_step[k] = (m_act[k] && m_el[k] >= m_p[k] && m_el[k] < m_p[k] + m_u[k]) ^ invert[k];
        e_dir[k]  = m_dir[k];
        e_busy[k] = m_act[k] || (m_pend[k] > 0);
        e_ovr[k]  = m_ovr[k];
        e_pos[k*POS_W +: POS_W] = POS_EN ? m_pos[k] : '0;
      end
      check("model_step", step, e_step);
      check("model_dir", dir, e_dir);
      check("model_busy", busy, e_busy);
      check("model_overrun", overrun, e_ovr);
      check("model_position", position, e_pos);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_timing(input int p, input int u, input int s);
    pre_n   = TW'(p);
    pulse_n = TW'(u);
    post_n  = TW'(s);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== '0 && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, '0);
  endtask

  task automatic one_step(input int k, input bit d, input string name);
    step_dir[k] = d;
    step_stb[k] = 1'b1;
    tick();
    step_stb = '0;
    wait_idle(name, 20);
  endtask

  logic [31:0] exp_q[$];
  logic [N_CH-1:0] rdir;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_pulses;
    bit prev;

    // Reset state: everything zero, step follows invert.
    invert = 4'b1010;
    tick();
    @(negedge clk);
    check("reset_step_eq_invert", step, 4'b1010);
    check("reset_dir", dir, '0);
    check("reset_busy", busy, '0);
    check("reset_overrun", overrun, '0);
    check("reset_position", position, '0);
    tick();
    reset  = 1'b0;
    invert = '0;
    tick();

    // Basic step on ch0: pre=2 pulse=3 post=4, strobe in cycle 0.
    set_timing(2, 3, 4);
    step_dir[0] = 1'b1;
    step_stb[0] = 1'b1;
    @(negedge clk);
    check("basic_busy_c0", busy[0], 1'b0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      step_stb = '0;
      @(negedge clk);
      check("basic_step", step[0], (c >= 3 && c <= 5));
      if (c == 1)  check("basic_dir", dir[0], 1'b1);
      if (c == 9)  check("basic_busy_hold", busy[0], 1'b1);
      if (c == 10) check("basic_busy_fall", busy[0], 1'b0);
    end
    check("basic_pos", position[0 +: POS_W], POS_EN ? 1 : 0);
    tick();

    // Queueing on ch1: three strobes one cycle apart, timing 1/1/1.
    set_timing(1, 1, 1);
    exp_q = {32'd2, 32'd5, 32'd8};
    n_pulses = 0;
    prev = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      step_dir[1] = 1'b1;
      step_stb    = (c <= 2) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (step[1] && !prev) begin
        n_pulses++;
        if (exp_q.size() > 0) check("queue_pulse_cycle", c, exp_q.pop_front());
      end
      prev = step[1];
      tick();
    end
    step_stb = '0;
    check("queue_pulse_count", n_pulses, 3);
    check("queue_overrun", overrun[1], 1'b0);
    check("queue_pos", position[1*POS_W +: POS_W], POS_EN ? 3 : 0);

    // Overrun on ch2: opposite dir in PULSE, then fill the pending queue.
    set_timing(2, 4, 30);
    for (int c = 0; c <= 22; c++) begin
      step_stb    = '0;
      step_dir[2] = 1'b1;
      clear_ovr   = 1'b0;
      if (c == 0) step_stb[2] = 1'b1;
      if (c == 4) begin step_stb[2] = 1'b1; step_dir[2] = 1'b0; end
      if (c == 5) clear_ovr = 1'b1;
      if (c >= 6 && c <= 21) step_stb[2] = 1'b1;
      @(negedge clk);
      if (c == 4)  check("ovr_in_pulse", step[2], 1'b1);
      if (c == 5)  check("ovr_dir_mismatch", overrun[2], 1'b1);
      if (c == 6)  check("ovr_cleared", overrun[2], 1'b0);
      if (c == 21) check("ovr_pend_15_ok", overrun[2], 1'b0);
      if (c == 22) check("ovr_pend_full", overrun[2], 1'b1);
      tick();
    end
    step_stb  = '0;
    clear_ovr = 1'b0;
    wait_idle("ovr_drain", 800);
    check("ovr_pos", position[2*POS_W +: POS_W], POS_EN ? 16 : 0);
    check("ovr_sticky", overrun[2], 1'b1);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    @(negedge clk);
    check("ovr_clear_idle", overrun[2], 1'b0);
    tick();

    // Wrap and clear on ch3.
    set_timing(1, 1, 1);
    for (int i = 0; i < 127; i++) one_step(3, 1'b1, "wrap_fill_idle");
    check("wrap_at_max", position[3*POS_W +: POS_W], POS_EN ? 8'h7F : 8'h00);
    one_step(3, 1'b1, "wrap_idle");
    check("wrap_to_min", position[3*POS_W +: POS_W], POS_EN ? 8'h80 : 8'h00);
    step_stb[3] = 1'b1;
    tick();
    step_stb  = '0;
    clear_pos = 1'b1;
    tick();
    clear_pos = 1'b0;
    @(negedge clk);
    check("clear_pos_in_pulse", step[3], 1'b1);
    check("clear_pos_wins", position[3*POS_W +: POS_W], 8'h00);
    wait_idle("clear_idle", 20);
    one_step(3, 1'b0, "neg_idle");
    check("neg_wrap", position[3*POS_W +: POS_W], POS_EN ? 8'hFF : 8'h00);

    // Async reset in the middle of a pulse on ch0.
    set_timing(2, 5, 2);
    step_dir[0] = 1'b1;
    step_stb[0] = 1'b1;
    tick();
    step_stb = '0;
    tick(); tick(); tick();
    @(negedge clk);
    check("areset_pulse_high", step[0], 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check("areset_step_drop", step[0], 1'b0);
    check("areset_busy", busy, '0);
    tick();
    reset = 1'b0;
    tick();
    enable = '0;
    for (int c = 0; c < 6; c++) begin
      step_stb = '1;
      step_dir = 4'b0101;
      @(negedge clk);
      check("disabled_busy", busy, '0);
      check("disabled_overrun", overrun, '0);
      tick();
    end
    step_stb = '0;
    enable   = '1;
    tick();

    // Independence with distinct per-channel polarity.
    invert = 4'b0110;
    @(negedge clk);
    check("indep_idle_invert", step, 4'b0110);
    tick();

    // Randomized phase; the compare process checks every cycle.
    rdir = '0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0)
        set_timing($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) invert = N_CH'($urandom);
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(0, 7) == 0) rdir[k] = ~rdir[k];
        step_stb[k] = ($urandom_range(0, 3) == 0);
        enable[k]   = ($urandom_range(0, 19) != 0);
      end
      step_dir  = rdir;
      clear_pos = ($urandom_range(0, 49) == 0);
      clear_ovr = ($urandom_range(0, 29) == 0);
      tick();
    end
    step_stb  = '0;
    clear_pos = 1'b0;
    clear_ovr = 1'b0;
    enable    = '1;
    wait_idle("final_drain", 500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_step_array.md
MOTOR_STEP_ARRAY -- requirements
Module: motor_step_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent step/dir channels.
REQ-002 SHALL have parameter TW, default 32: width of the timing values in clock cycles.
REQ-003 SHALL have parameter PEND_W, default 4: width of each channel's pending-step counter; depth is 2^PEND_W-1.
REQ-004 SHALL have parameter POS_W, default 32: width of each position counter.
REQ-005 SHALL have ports, one per line:
- clk  in  1  system clock, all logic on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- step_stb  in  N_CH  one-cycle step request per channel.
- step_dir  in  N_CH  requested direction, sampled with step_stb.
- enable  in  N_CH  channel enable.
- pre_n  in  TW  dir-to-step setup cycles, shared.
- pulse_n  in  TW  step-active cycles, shared.
- post_n  in  TW  step-inactive hold cycles, shared.
- invert  in  N_CH  per-channel step output polarity.
- clear_pos  in  1  synchronous zero of all position counters.
- clear_ovr  in  1  synchronous clear of all overrun flags.
- step  out  N_CH  motor step outputs.
- dir  out  N_CH  motor direction outputs.
- busy  out  N_CH  channel not idle, or pending steps nonzero.
- overrun  out  N_CH  sticky dropped-request flag.
- position  out  N_CH*POS_W  signed positions; channel k occupies bits [k*POS_W +: POS_W].

Function
REQ-006 Each channel SHALL run the states IDLE, PRE, PULSE and POST.
- IDLE to PRE: on an accepted request.
- PRE to PULSE, PULSE to POST: each on its counter expiry.
- POST exits to PRE if pending is nonzero (decrementing pending), otherwise to IDLE.
REQ-007 On accepting a request, the channel SHALL latch pre_n, pulse_n and post_n.
- Each phase then lasts max(latched value, 1) cycles.
- Input changes mid-step have no effect on the step in progress.
REQ-008 A request SHALL be accepted in IDLE when step_stb=1 and enable=1.
- dir is updated to step_dir on the next edge.
- The state is PRE on the same edge.
REQ-009 The raw step level SHALL be 1 only in PULSE; the output SHALL be step = raw XOR invert.
REQ-010 A request while not IDLE, with step_dir equal to the latched dir and pending below its maximum, SHALL increment pending.
REQ-011 A request while not IDLE SHALL be dropped and set overrun when either holds:
- step_dir differs from the latched dir;
- pending is at its maximum.
REQ-012 With enable=0:
- step_stb SHALL be ignored, without setting overrun.
- pending SHALL be cleared.
- A step in progress SHALL complete through POST, then go to IDLE.
REQ-013 On each PRE-to-PULSE transition, position SHALL change by +1 if dir=1 and -1 if dir=0, wrapping modulo 2^POS_W.
REQ-014 clear_pos coinciding with a position update SHALL leave position at 0 (clear wins).
REQ-015 clear_ovr coinciding with a new overrun event SHALL leave overrun at 1 (set wins).
REQ-016 busy SHALL be 1 exactly when the state is not IDLE or pending is nonzero.
REQ-017 Back-to-back queued steps SHALL have a period of exactly pre+pulse+post cycles, with no idle gap.

Reset
REQ-018 While reset is high, the following SHALL hold:
- every channel in IDLE;
- pending, counters, latched timing, dir, overrun and position all 0;
- step = invert.
REQ-019 Reset asserted mid-pulse SHALL terminate the pulse immediately, without waiting for a clock edge.

Configuration
REQ-020 With macro MOTOR_STEP_POSITION_EN defined, the position counters SHALL be built as specified.
REQ-021 Without MOTOR_STEP_POSITION_EN, position SHALL be tied to 0, clear_pos SHALL be ignored, and no counter logic SHALL be built.

Structure
REQ-022 Package motor_step_pkg SHALL hold the following, and nothing else:
- the state enum (IDLE, PRE, PULSE, POST);
- default parameter constants.
REQ-023 Sub-module motor_step_chan SHALL implement one channel and be instantiated N_CH times in a generate loop.
- Only timing inputs and clear signals are shared between channels.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Basic step: pre=2, pulse=3, post=4, invert=0, ch0 strobe dir=1 at cycle 0 -> dir=1 from cycle 1; step=1 cycles 3-5; busy falls at cycle 10; position0=+1.
- Queueing: 3 same-dir strobes 1 cycle apart, timing 1/1/1 -> 3 pulses, period 3, overrun=0, position=+3.
- Overrun: opposite-dir strobe during PULSE, and then 16 strobes with PEND_W=4 -> overrun=1, excess requests dropped; clear_ovr -> overrun=0.
- Wrap and clear: position at 0x7FFFFFFF, +1 step -> 0x80000000; clear_pos on the same cycle as a step -> 0.
- Async reset: reset pulsed mid-PULSE -> step drops before the next clk edge; then enable=0 with strobe -> no activity, overrun=0.
- Channel independence and build option: with N_CH=4 and different invert per channel, all channels remain independent; with MOTOR_STEP_POSITION_EN undefined, position stays 0.
